pixel_sum_stream: RTL and testbench
===================================

# pixel_sum_stream

Streaming, parametrised pixel-sum engine for the image front end. Accepts an image one row per handshake, accumulates the total pixel sum and the left-region sum over HEIGHT rows, then presents both with a valid/ready result handshake. Replaces the flat combinational binary-image summer: multi-bit pixels, a configurable left/right split column, backpressure and frame abort.

## Interface
- HEIGHT, 28, rows per frame (shared constant from global_params)
- LENGTH, 28, pixels per row (shared constant from global_params)
- PIX_W, 1, bits per pixel, unsigned
- SPLIT_COL, LENGTH/2, columns 0..SPLIT_COL-1 count toward sum_left; legal range 0..LENGTH
- SUM_W, $clog2(HEIGHT*LENGTH*(2**PIX_W-1)+1), result width (derived, not overridden)
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  reset, asynchronous assert, active-low
- clear  in  1  synchronous frame abort
- row_valid  in  1  row_data valid
- row_ready  out  1  engine accepts a row this cycle
- row_data  in  LENGTH*PIX_W  pixel j at [j*PIX_W +: PIX_W], column 0 leftmost
- sum_valid  out  1  result held on sum/sum_left
- sum_ready  in  1  consumer accepts result
- sum  out  SUM_W  total of all pixels in frame
- sum_left  out  SUM_W  total of pixels in columns < SPLIT_COL

## Operation
- States: ACCUM, DONE. Reset state ACCUM.
- ACCUM: row_ready=1, sum_valid=0. On row_valid&&row_ready: acc_all += rowsum(all columns), acc_left += rowsum(columns < SPLIT_COL), row_cnt++. When the accepted row has row_cnt==HEIGHT-1: load sum/sum_left with final totals, zero accumulators and row_cnt, go to DONE.
- DONE: row_ready=0, sum_valid=1, sum/sum_left stable. On sum_ready: go to ACCUM; sum/sum_left keep last values (only sum_valid qualifies them).
- clear (any state): accumulators, row_cnt zeroed, state to ACCUM, sum_valid=0; any row presented that cycle is discarded; clear has priority over all handshakes.
- Arithmetic: all unsigned, zero-extended to SUM_W; no overflow possible by construction of SUM_W. SPLIT_COL=0 gives sum_left=0; SPLIT_COL=LENGTH gives sum_left=sum.
- Row reduction is combinational within the accept cycle (no input pipeline).

## Timing
- Reset values: row_ready=1 (after reset released), sum_valid=0, sum=0, sum_left=0, row_cnt=0, accumulators 0.
- rst_n low asynchronously forces reset values mid-frame; partial frame is lost.
- Latency: sum_valid rises the cycle after the HEIGHT-th row handshake.
- Throughput: one row per cycle in ACCUM; one bubble cycle per frame minimum (DONE held ≥1 cycle); back-to-back frames at HEIGHT+1 cycles when sum_ready tied high.
- row_ready is a function of state only (no combinational path from sum_ready or row_valid).
- Gaps (row_valid=0) in ACCUM do not alter accumulators or row_cnt.

## Structure
- HEIGHT, LENGTH stay in global_params; add a pixel-sum width helper function there for reuse by downstream classifiers.
- One sub-module: row_popsum (combinational, parameters LENGTH, PIX_W, SPLIT_COL; outputs row total and row left total, width $clog2(LENGTH*(2**PIX_W-1)+1)).
- Top holds FSM, row counter ($clog2(HEIGHT) bits), accumulators, result registers.

## Test plan
- HEIGHT=4, LENGTH=4, PIX_W=1, SPLIT_COL=2; four rows 4'b1111 back-to-back, sum_ready=1 -> sum_valid one cycle after 4th accept, sum=16, sum_left=8.
- Same config, rows with only column 0 set (row_data=4'b0001) -> sum=4, sum_left=4; only column 3 set -> sum=4, sum_left=0.
- PIX_W=8, LENGTH=4, HEIGHT=4, all pixels 255 -> sum=4080 (SUM_W=12), sum_left=2040; no wrap.
- sum_ready=0 for 5 cycles in DONE with row_valid=1 -> row_ready=0, sum/sum_left stable, no row consumed; after sum_ready pulse, next rows accepted and next frame correct.
- Assert clear after 2 rows, then send a full frame of 4'b1111 -> result 16/8 (partial rows discarded); clear in DONE -> sum_valid drops next cycle.
- Drop rst_n asynchronously mid-frame (between edges) -> outputs reach reset values immediately; after release, a full frame yields correct totals.

Source files
------------

// File: rtl/global_params.sv
// Shared image geometry and width helpers for the image front end.
package global_params;

  localparam int unsigned HEIGHT = 28;
  localparam int unsigned LENGTH = 28;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } sum_state_t;

  // Bits needed to hold the sum of `count` unsigned pixels of `pix_w` bits.
  function automatic int unsigned pix_sum_w(input int unsigned count, input int unsigned pix_w);
    return $clog2(count * ((32'd1 << pix_w) - 32'd1) + 32'd1);
  endfunction

endpackage

// File: rtl/pixel_sum_stream_row_popsum.sv
// Combinational reduction of one row: total of all pixels and of the left region.
module row_popsum
  import global_params::*;
#(
  parameter int unsigned LENGTH    = global_params::LENGTH,
  parameter int unsigned PIX_W     = 1,
  parameter int unsigned SPLIT_COL = LENGTH / 2,
  localparam int unsigned ROW_W    = pix_sum_w(LENGTH, PIX_W)
) (
  input  logic [LENGTH*PIX_W-1:0] row_data,
  output logic [ROW_W-1:0]        row_total,
  output logic [ROW_W-1:0]        row_left
);

  // Column mask built by shifting so SPLIT_COL=0 and SPLIT_COL=LENGTH need no special case.
  localparam logic [LENGTH-1:0] ALL_COLS  = '1;
  localparam logic [LENGTH-1:0] LEFT_MASK = ALL_COLS >> (LENGTH - SPLIT_COL);

  // Sum every pixel, and separately the pixels left of the split column.
  always_comb begin
    row_total = '0;
    row_left  = '0;
    for (int unsigned j = 0; j < LENGTH; j++) begin
      row_total = row_total + ROW_W'(row_data[j*PIX_W +: PIX_W]);
      if (LEFT_MASK[j]) begin
        row_left = row_left + ROW_W'(row_data[j*PIX_W +: PIX_W]);
      end
    end
  end

endmodule

// File: rtl/pixel_sum_stream.sv
// Streaming frame pixel-sum engine: one row per handshake, result via valid/ready.
module pixel_sum_stream
  import global_params::*;
#(
  parameter int unsigned HEIGHT    = global_params::HEIGHT,
  parameter int unsigned LENGTH    = global_params::LENGTH,
  parameter int unsigned PIX_W     = 1,
  parameter int unsigned SPLIT_COL = LENGTH / 2,
  localparam int unsigned SUM_W    = pix_sum_w(HEIGHT * LENGTH, PIX_W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    row_valid,
  output logic                    row_ready,
  input  logic [LENGTH*PIX_W-1:0] row_data,
  output logic                    sum_valid,
  input  logic                    sum_ready,
  output logic [SUM_W-1:0]        sum,
  output logic [SUM_W-1:0]        sum_left
);

  localparam int unsigned ROW_W = pix_sum_w(LENGTH, PIX_W);
  localparam int unsigned CNT_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  sum_state_t       state, next_state;
  logic [CNT_W-1:0] row_cnt;
  logic [SUM_W-1:0] acc_all, acc_left;
  logic [ROW_W-1:0] row_total, row_left;
  logic             accept, last_row;

  row_popsum #(
    .LENGTH    (LENGTH),
    .PIX_W     (PIX_W),
    .SPLIT_COL (SPLIT_COL)
  ) u_row_popsum (
    .row_data  (row_data),
    .row_total (row_total),
    .row_left  (row_left)
  );

  assign accept   = row_valid && row_ready;
  assign last_row = (row_cnt == CNT_W'(HEIGHT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs; outputs depend on state only.
  always_comb begin
    next_state = state;
    row_ready  = 1'b0;
    sum_valid  = 1'b0;
    case (state)
      ACCUM: begin
        row_ready = 1'b1;
        if (accept && last_row) next_state = DONE;
      end
      DONE: begin
        sum_valid = 1'b1;
        if (sum_ready) next_state = ACCUM;
      end
      default: next_state = ACCUM;
    endcase
    if (clear) next_state = ACCUM;
  end

  // Accumulators, row counter and result registers; clear discards the presented row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_all  <= '0;
      acc_left <= '0;
      row_cnt  <= '0;
      sum      <= '0;
      sum_left <= '0;
    end else if (clear) begin
      acc_all  <= '0;
      acc_left <= '0;
      row_cnt  <= '0;
    end else if (accept) begin
      if (last_row) begin
        sum      <= acc_all + SUM_W'(row_total);
        sum_left <= acc_left + SUM_W'(row_left);
        acc_all  <= '0;
        acc_left <= '0;
        row_cnt  <= '0;
      end else begin
        acc_all  <= acc_all + SUM_W'(row_total);
        acc_left <= acc_left + SUM_W'(row_left);
        row_cnt  <= row_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pixel_sum_stream.sv
// Directed self-checking bench for pixel_sum_stream (4x4 frames, 1-bit and 8-bit pixels).
module tb_pixel_sum_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Group A: 1-bit pixels, three split columns sharing the same inputs.
  logic        a_clear = 1'b0, a_row_valid = 1'b0, a_sum_ready = 1'b0;
  logic [3:0]  a_row_data = '0;
  logic        a_row_ready, a_sum_valid, c_row_ready, c_sum_valid, d_row_ready, d_sum_valid;
  logic [4:0]  a_sum, a_sum_left, c_sum, c_sum_left, d_sum, d_sum_left;

  // Group B: 8-bit pixels.
  logic        b_clear = 1'b0, b_row_valid = 1'b0, b_sum_ready = 1'b0;
  logic [31:0] b_row_data = '0;
  logic        b_row_ready, b_sum_valid;
  logic [11:0] b_sum, b_sum_left;

  int unsigned total = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  pixel_sum_stream #(.HEIGHT(4), .LENGTH(4), .PIX_W(1), .SPLIT_COL(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .row_valid(a_row_valid), .row_ready(a_row_ready),
    .row_data(a_row_data), .sum_valid(a_sum_valid), .sum_ready(a_sum_ready),
    .sum(a_sum), .sum_left(a_sum_left));

  pixel_sum_stream #(.HEIGHT(4), .LENGTH(4), .PIX_W(1), .SPLIT_COL(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .row_valid(a_row_valid), .row_ready(c_row_ready),
    .row_data(a_row_data), .sum_valid(c_sum_valid), .sum_ready(a_sum_ready),
    .sum(c_sum), .sum_left(c_sum_left));

  pixel_sum_stream #(.HEIGHT(4), .LENGTH(4), .PIX_W(1), .SPLIT_COL(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .row_valid(a_row_valid), .row_ready(d_row_ready),
    .row_data(a_row_data), .sum_valid(d_sum_valid), .sum_ready(a_sum_ready),
    .sum(d_sum), .sum_left(d_sum_left));

  pixel_sum_stream #(.HEIGHT(4), .LENGTH(4), .PIX_W(8), .SPLIT_COL(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .row_valid(b_row_valid), .row_ready(b_row_ready),
    .row_data(b_row_data), .sum_valid(b_sum_valid), .sum_ready(b_sum_ready),
    .sum(b_sum), .sum_left(b_sum_left));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      passed++;
    end
  endtask

  // Four group-A rows back to back (row i = rows[4*i +: 4]), then result checks.
  task automatic frame_a(input string tag, input logic [15:0] rows, input int unsigned es,
                         input int unsigned el, input int unsigned ecl, input int unsigned edl);
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      check({tag, "_rdy"}, 32'(a_row_ready), 32'd1);
      check({tag, "_vld_early"}, 32'(a_sum_valid), 32'd0);
      a_row_valid = 1'b1;
      a_row_data  = rows[i*4 +: 4];
    end
    @(negedge clk);
    a_row_valid = 1'b0;
    check({tag, "_vld"}, 32'(a_sum_valid), 32'd1);
    check({tag, "_rdy_done"}, 32'(a_row_ready), 32'd0);
    check({tag, "_sum"}, 32'(a_sum), es);
    check({tag, "_left"}, 32'(a_sum_left), el);
    check({tag, "_c_vld"}, 32'(c_sum_valid), 32'd1);
    check({tag, "_c_sum"}, 32'(c_sum), es);
    check({tag, "_c_left"}, 32'(c_sum_left), ecl);
    check({tag, "_d_vld"}, 32'(d_sum_valid), 32'd1);
    check({tag, "_d_sum"}, 32'(d_sum), es);
    check({tag, "_d_left"}, 32'(d_sum_left), edl);
  endtask

  // Four identical group-B rows back to back, then result checks.
  task automatic frame_b(input string tag, input logic [31:0] row, input int unsigned es,
                         input int unsigned el);
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      check({tag, "_rdy"}, 32'(b_row_ready), 32'd1);
      check({tag, "_vld_early"}, 32'(b_sum_valid), 32'd0);
      b_row_valid = 1'b1;
      b_row_data  = row;
    end
    @(negedge clk);
    b_row_valid = 1'b0;
    check({tag, "_vld"}, 32'(b_sum_valid), 32'd1);
    check({tag, "_sum"}, 32'(b_sum), es);
    check({tag, "_left"}, 32'(b_sum_left), el);
  endtask

  initial begin
    #2;
    check("rst_a_rdy", 32'(a_row_ready), 32'd1);
    check("rst_a_vld", 32'(a_sum_valid), 32'd0);
    check("rst_a_sum", 32'(a_sum), 32'd0);
    check("rst_a_left", 32'(a_sum_left), 32'd0);
    check("rst_c_rdy", 32'(c_row_ready), 32'd1);
    check("rst_d_rdy", 32'(d_row_ready), 32'd1);
    check("rst_b_vld", 32'(b_sum_valid), 32'd0);
    check("rst_b_sum", 32'(b_sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_sum_ready = 1'b1;

    // Full, column-0-only and column-3-only frames with the consumer always ready.
    frame_a("ones", 16'hFFFF, 16, 8, 16, 0);
    @(negedge clk);
    check("ones_vld_drop", 32'(a_sum_valid), 32'd0);
    check("ones_sum_hold", 32'(a_sum), 32'd16);
    frame_a("col0", 16'h1111, 4, 4, 4, 0);
    frame_a("col3", 16'h8888, 4, 0, 4, 0);

    // Backpressure: result held for 5 cycles while a row is offered.
    @(negedge clk);
    a_sum_ready = 1'b0;
    frame_a("ramp", 16'hF731, 10, 7, 10, 0);
    a_row_valid = 1'b1;
    a_row_data  = 4'b1111;
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rdy", 32'(a_row_ready), 32'd0);
      check("bp_vld", 32'(a_sum_valid), 32'd1);
      check("bp_sum", 32'(a_sum), 32'd10);
      check("bp_left", 32'(a_sum_left), 32'd7);
    end
    a_sum_ready = 1'b1;
    @(negedge clk);
    a_row_valid = 1'b0;
    check("bp_release_vld", 32'(a_sum_valid), 32'd0);
    check("bp_release_rdy", 32'(a_row_ready), 32'd1);
    frame_a("after_bp", 16'h6666, 8, 4, 8, 0);

    // Clear after two accepted rows; the row presented with clear is dropped.
    @(negedge clk);
    a_row_valid = 1'b1;
    a_row_data  = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    a_clear = 1'b1;
    @(negedge clk);
    a_clear = 1'b0;
    a_row_valid = 1'b0;
    check("clr_vld", 32'(a_sum_valid), 32'd0);
    check("clr_rdy", 32'(a_row_ready), 32'd1);
    frame_a("after_clr", 16'hFFFF, 16, 8, 16, 0);

    // Clear while a result is pending.
    @(negedge clk);
    a_sum_ready = 1'b0;
    frame_a("pre_clr_done", 16'h1111, 4, 4, 4, 0);
    a_clear = 1'b1;
    @(negedge clk);
    a_clear = 1'b0;
    check("clr_done_vld", 32'(a_sum_valid), 32'd0);
    check("clr_done_rdy", 32'(a_row_ready), 32'd1);
    check("clr_done_sum", 32'(a_sum), 32'd4);
    a_sum_ready = 1'b1;

    // Asynchronous reset between edges in the middle of a frame.
    @(negedge clk);
    a_row_valid = 1'b1;
    a_row_data  = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    a_row_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sum", 32'(a_sum), 32'd0);
    check("arst_left", 32'(a_sum_left), 32'd0);
    check("arst_vld", 32'(a_sum_valid), 32'd0);
    check("arst_rdy", 32'(a_row_ready), 32'd1);
    check("arst_c_sum", 32'(c_sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    frame_a("after_arst", 16'hFFFF, 16, 8, 16, 0);

    // 8-bit pixels: saturated frame needs the full 12-bit result.
    b_sum_ready = 1'b1;
    frame_b("b_max", 32'hFFFF_FFFF, 4080, 2040);
    frame_b("b_ramp", 32'h0403_0201, 40, 12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
